// File: rtl/mtimer_if.sv
// Bus bundle between the pCPU MMIO address mapper and the mtimer responder.
// The master drives offset/data/strobes; the slave returns read data and the interrupt level.
interface mtimer_if;
   logic [2:0]  a;
   logic [31:0] d;
   logic        we;
   logic        rd;
   logic [31:0] spo;
   logic        irq;

   modport master (
      output a, d, we, rd,
      input  spo, irq
   );

   modport slave (
      input  a, d, we, rd,
      output spo, irq
   );
endinterface

// File: rtl/mtimer.sv
// Memory-mapped 64-bit timer: prescaled up-counter, 64-bit compare with optional
// auto-reload, W1C match flag, level interrupt and a free-running cycle counter.
module mtimer (
   input  logic     clk,
   input  logic     rst,
   mtimer_if.slave  bus
);

   localparam logic [2:0] OFS_CTRL     = 3'd0;
   localparam logic [2:0] OFS_PRESCALE = 3'd1;
   localparam logic [2:0] OFS_COUNT_LO = 3'd2;
   localparam logic [2:0] OFS_COUNT_HI = 3'd3;
   localparam logic [2:0] OFS_CMP_LO   = 3'd4;
   localparam logic [2:0] OFS_CMP_HI   = 3'd5;
   localparam logic [2:0] OFS_STATUS   = 3'd6;
   localparam logic [2:0] OFS_CYCLES   = 3'd7;

   logic        r_en;
   logic        r_ie;
   logic        r_reload;
   logic [15:0] r_prescale;
   logic [15:0] r_pcnt;
   logic [63:0] r_count;
   logic [31:0] r_hi_snap;
   logic [63:0] r_compare;
   logic        r_pending;
   logic [31:0] r_cycles;

   logic        w_wr_ctrl;
   logic        w_wr_pre;
   logic        w_wr_cnt_lo;
   logic        w_wr_cnt_hi;
   logic        w_wr_cmp_lo;
   logic        w_wr_cmp_hi;
   logic        w_wr_status;
   logic        w_tick;
   logic [63:0] w_next;
   logic        w_match;

   assign w_wr_ctrl   = bus.we && (bus.a == OFS_CTRL);
   assign w_wr_pre    = bus.we && (bus.a == OFS_PRESCALE);
   assign w_wr_cnt_lo = bus.we && (bus.a == OFS_COUNT_LO);
   assign w_wr_cnt_hi = bus.we && (bus.a == OFS_COUNT_HI);
   assign w_wr_cmp_lo = bus.we && (bus.a == OFS_CMP_LO);
   assign w_wr_cmp_hi = bus.we && (bus.a == OFS_CMP_HI);
   assign w_wr_status = bus.we && (bus.a == OFS_STATUS) && bus.d[0];

   assign w_tick  = r_en && (r_pcnt == r_prescale);
   assign w_next  = r_count + 64'd1;
   // Match uses the pre-write next value and the compare register as it stood before this edge.
   assign w_match = w_tick && (w_next == r_compare);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en       <= 1'b0;
         r_ie       <= 1'b0;
         r_reload   <= 1'b0;
         r_prescale <= 16'd0;
         r_compare  <= 64'hffff_ffff_ffff_ffff;
      end else begin
         if (w_wr_ctrl) begin
            r_en     <= bus.d[0];
            r_ie     <= bus.d[1];
            r_reload <= bus.d[2];
         end
         if (w_wr_pre) begin
            r_prescale <= bus.d[15:0];
         end
         if (w_wr_cmp_lo) begin
            r_compare[31:0] <= bus.d;
         end
         if (w_wr_cmp_hi) begin
            r_compare[63:32] <= bus.d;
         end
      end
   end

   // A PRESCALE write restarts the divider; a coincident tick has already been decoded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt <= 16'd0;
      end else if (w_wr_pre || w_tick) begin
         r_pcnt <= 16'd0;
      end else if (r_en) begin
         r_pcnt <= r_pcnt + 16'd1;
      end
   end

   // Bus writes to either count half take priority over the tick increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 64'd0;
      end else if (w_wr_cnt_lo) begin
         r_count[31:0] <= bus.d;
      end else if (w_wr_cnt_hi) begin
         r_count[63:32] <= bus.d;
      end else if (w_tick) begin
         r_count <= (w_match && r_reload) ? 64'd0 : w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi_snap <= 32'd0;
         r_pending <= 1'b0;
         r_cycles  <= 32'd0;
      end else begin
         r_cycles <= r_cycles + 32'd1;
         if (bus.rd && (bus.a == OFS_COUNT_LO)) begin
            r_hi_snap <= r_count[63:32];
         end
         if (w_match) begin
            r_pending <= 1'b1;
         end else if (w_wr_status) begin
            r_pending <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.spo = 32'd0;
      case (bus.a)
         OFS_CTRL:     bus.spo = {29'd0, r_reload, r_ie, r_en};
         OFS_PRESCALE: bus.spo = {16'd0, r_prescale};
         OFS_COUNT_LO: bus.spo = r_count[31:0];
         OFS_COUNT_HI: bus.spo = r_hi_snap;
         OFS_CMP_LO:   bus.spo = r_compare[31:0];
         OFS_CMP_HI:   bus.spo = r_compare[63:32];
         OFS_STATUS:   bus.spo = {31'd0, r_pending};
         OFS_CYCLES:   bus.spo = r_cycles;
         default:      bus.spo = 32'd0;
      endcase
   end

   assign bus.irq = r_pending && r_ie;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: reset values, prescaled counting, match/irq,
// auto-reload, 64-bit wrap with snapshot coherence, and same-cycle collisions.
module tb_mtimer;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_mis;
   logic [31:0] v;

   mtimer_if bus ();

   mtimer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Each bus task starts and ends 1 ns after a rising edge and spans exactly one edge.
   task automatic wr(input logic [2:0] addr, input logic [31:0] data);
      bus.a  = addr;
      bus.d  = data;
      bus.we = 1'b1;
      @(posedge clk);
      #1;
      bus.we = 1'b0;
   endtask

   task automatic rd_reg(input logic [2:0] addr, output logic [31:0] data);
      bus.a  = addr;
      bus.rd = 1'b1;
      #1;
      data = bus.spo;
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
   endtask

   task automatic peek(input logic [2:0] addr, output logic [31:0] data);
      bus.a = addr;
      #1;
      data = bus.spo;
   endtask

   task automatic check_reset_reads(input string tag);
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), v);
         chk_val($sformatf("%s_off%0d", tag, i), {32'd0, v},
                 (i == 4 || i == 5) ? 64'h0000_0000_ffff_ffff : 64'd0);
      end
      chk_val({tag, "_irq"}, {63'd0, bus.irq}, 64'd0);
   endtask

   initial begin
      logic [31:0] exp_cnt [4];
      logic        exp_irq [4];
      n_cmp  = 0;
      n_mis  = 0;
      rst    = 1'b1;
      bus.a  = 3'd0;
      bus.d  = 32'd0;
      bus.we = 1'b0;
      bus.rd = 1'b0;

      // Power-on reset state, sampled while reset is held
      repeat (2) @(posedge clk);
      #1;
      check_reset_reads("por");
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      peek(3'd7, v);
      chk_val("cycles_after_por", {32'd0, v}, 64'd5);

      // Prescale 3: ten ticks in 40 enabled clocks
      wr(3'd1, 32'd3);
      wr(3'd0, 32'd1);
      repeat (40) @(posedge clk);
      #1;
      rd_reg(3'd2, v);
      chk_val("pre3_count_lo", {32'd0, v}, 64'd10);
      rd_reg(3'd3, v);
      chk_val("pre3_count_hi", {32'd0, v}, 64'd0);

      // One-shot match at 5 with interrupt enabled
      wr(3'd0, 32'd0);
      wr(3'd2, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd4, 32'd5);
      wr(3'd5, 32'd0);
      wr(3'd1, 32'd0);
      wr(3'd0, 32'd3);
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         peek(3'd2, v);
         chk_val($sformatf("oneshot_cnt%0d", i), {32'd0, v}, 64'(i));
         chk_val($sformatf("oneshot_irq%0d", i), {63'd0, bus.irq}, (i >= 5) ? 64'd1 : 64'd0);
      end
      wr(3'd6, 32'd1);
      chk_val("w1c_irq", {63'd0, bus.irq}, 64'd0);
      peek(3'd6, v);
      chk_val("w1c_status", {32'd0, v}, 64'd0);

      // Auto-reload at compare 4
      wr(3'd0, 32'd0);
      wr(3'd2, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd4, 32'd4);
      wr(3'd5, 32'd0);
      wr(3'd6, 32'd1);
      wr(3'd1, 32'd0);
      wr(3'd0, 32'd7);
      exp_cnt = '{32'd1, 32'd2, 32'd3, 32'd0};
      exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         peek(3'd2, v);
         chk_val($sformatf("reload_a_cnt%0d", i), {32'd0, v}, {32'd0, exp_cnt[i]});
         chk_val($sformatf("reload_a_irq%0d", i), {63'd0, bus.irq}, {63'd0, exp_irq[i]});
      end
      wr(3'd6, 32'd1);
      peek(3'd2, v);
      chk_val("reload_b_cnt0", {32'd0, v}, 64'd1);
      chk_val("reload_b_irq0", {63'd0, bus.irq}, 64'd0);
      exp_cnt = '{32'd2, 32'd3, 32'd0, 32'd1};
      exp_irq = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         peek(3'd2, v);
         chk_val($sformatf("reload_b_cnt%0d", i + 1), {32'd0, v}, {32'd0, exp_cnt[i]});
         chk_val($sformatf("reload_b_irq%0d", i + 1), {63'd0, bus.irq}, {63'd0, exp_irq[i]});
      end

      // Collision: W1C on the same edge as a match leaves pending set
      wr(3'd6, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      peek(3'd2, v);
      chk_val("coll_pre_cnt", {32'd0, v}, 64'd3);
      wr(3'd6, 32'd1);
      peek(3'd6, v);
      chk_val("coll_w1c_status", {32'd0, v}, 64'd1);
      chk_val("coll_w1c_irq", {63'd0, bus.irq}, 64'd1);
      peek(3'd2, v);
      chk_val("coll_w1c_cnt", {32'd0, v}, 64'd0);

      // Collision: COUNT_LO write on a tick edge drops the increment
      wr(3'd2, 32'd100);
      peek(3'd2, v);
      chk_val("coll_wr_cnt", {32'd0, v}, 64'd100);
      wr(3'd0, 32'd0);
      peek(3'd2, v);
      chk_val("coll_wr_next", {32'd0, v}, 64'd101);

      // 64-bit wrap: ...fffe -> ...ffff -> 0
      wr(3'd4, 32'h0001_2345);
      wr(3'd5, 32'd0);
      wr(3'd3, 32'hffff_ffff);
      wr(3'd2, 32'hffff_fffe);
      wr(3'd0, 32'd1);
      rd_reg(3'd2, v);
      chk_val("wrap_lo0", {32'd0, v}, 64'h0000_0000_ffff_fffe);
      rd_reg(3'd2, v);
      chk_val("wrap_lo1", {32'd0, v}, 64'h0000_0000_ffff_ffff);
      rd_reg(3'd2, v);
      chk_val("wrap_lo2", {32'd0, v}, 64'd0);
      rd_reg(3'd3, v);
      chk_val("wrap_hi2", {32'd0, v}, 64'd0);

      // Snapshot at count = 0x1_00000000 with prescale 3
      wr(3'd0, 32'd0);
      wr(3'd1, 32'd3);
      wr(3'd3, 32'd0);
      wr(3'd2, 32'hffff_ffff);
      wr(3'd0, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      rd_reg(3'd2, v);
      chk_val("snap_lo", {32'd0, v}, 64'd0);
      rd_reg(3'd3, v);
      chk_val("snap_hi", {32'd0, v}, 64'd1);

      // Snapshot coherence across a carry between LO and HI reads
      wr(3'd0, 32'd0);
      wr(3'd1, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd2, 32'hffff_ffff);
      wr(3'd0, 32'd1);
      rd_reg(3'd2, v);
      chk_val("carry_lo", {32'd0, v}, 64'h0000_0000_ffff_ffff);
      rd_reg(3'd3, v);
      chk_val("carry_hi", {32'd0, v}, 64'd0);
      rd_reg(3'd2, v);
      chk_val("carry_lo_next", {32'd0, v}, 64'd1);
      rd_reg(3'd3, v);
      chk_val("carry_hi_next", {32'd0, v}, 64'd1);

      // Reset asserted mid-count with irq high
      wr(3'd0, 32'd0);
      wr(3'd2, 32'd0);
      wr(3'd3, 32'd0);
      wr(3'd4, 32'd2);
      wr(3'd5, 32'd0);
      wr(3'd0, 32'd3);
      repeat (2) @(posedge clk);
      #1;
      chk_val("pre_rst_irq", {63'd0, bus.irq}, 64'd1);
      rst = 1'b1;
      #1;
      check_reset_reads("midrst");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      peek(3'd7, v);
      chk_val("midrst_cycles", {32'd0, v}, 64'd3);
      peek(3'd2, v);
      chk_val("midrst_count_held", {32'd0, v}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mtimer.md
# mtimer

Memory-mapped 64-bit timer that sits on the pCPU MMIO bus at 0x9b000000 as a bus responder. It decodes word offsets driven by the address mapper, returns read data combinationally with zero wait states, and latches writes on the clock edge. It provides a prescaled 64-bit up-counter, a 64-bit compare with optional auto-reload, a W1C match flag, and a level interrupt routed to the interrupt unit.

## Interface
- No parameters.
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- a  input  3  word offset (bus address [4:2])
- d  input  32  write data
- we  input  1  write strobe, one write per cycle it is high
- rd  input  1  read strobe, used only for the snapshot side effect
- spo  output  32  read data, combinational from `a` and registers
- irq  output  1  level interrupt = pending & CTRL.ie

## Operation
- Register map (word offset: name):
  - 0: CTRL. [0] en, [1] ie, [2] reload; other bits read 0.
  - 1: PRESCALE [15:0]. A tick occurs every PRESCALE+1 enabled clocks. Any write clears the prescale counter `pcnt`.
  - 2: COUNT_LO. Read returns count[31:0]. A clock edge with rd=1 and a=2 copies count[63:32] into `hi_snap`. Write sets count[31:0].
  - 3: COUNT_HI. Read returns `hi_snap`. Write sets count[63:32].
  - 4/5: COMPARE_LO/HI, read/write.
  - 6: STATUS. [0] pending. Writing 1 to d[0] clears it.
  - 7: CYCLES, free-running 32-bit clock counter. Read-only; writes are ignored.
- Prescaler, when en=1:
  - If pcnt==PRESCALE: pcnt<=0 and tick=1.
  - Otherwise pcnt<=pcnt+1.
  - When en=0, pcnt and count hold.
- On a tick, next = count+1, which wraps modulo 2^64.
  - If next==compare: pending<=1. If reload=1, count<=0; otherwise count<=next.
  - If next!=compare: count<=next.
- Simultaneous events:
  - A write to offset 2 or 3 in a tick cycle wins. The tick increment is dropped; the match check still uses the pre-write `next`.
  - A match-set and a STATUS W1C in the same cycle: set wins, so pending stays 1.
  - A write to COMPARE takes effect for matches starting the following cycle.
  - A write to PRESCALE in a cycle where a tick would occur: the tick still occurs, and pcnt<=0.
- Reset values:
  - CTRL, PRESCALE, pcnt, count, hi_snap, pending, and CYCLES are all 0.
  - compare is 64'hffff_ffff_ffff_ffff.
  - irq=0. spo is 0 at a=0.

## Timing
- Reads: spo is valid in the same cycle `a` is presented. There are no wait states; the bus treats ready as 1.
- Writes: registers update on the rising clk edge where we=1. A read in the next cycle returns the new value.
- Match latency:
  - pending rises on the edge of the tick that produces count==compare.
  - irq rises in the same cycle as pending, because irq is combinational from registers.
- rst asserted mid-count: everything returns to reset values immediately. Counting does not resume until CTRL.en is written again.
- CYCLES increments every clk, including when en=0, and wraps at 2^32.

## Test plan
- Reset:
  - Stimulus: assert rst mid-count.
  - Required response: irq=0; reads of offsets 0..7 return 0, except offsets 4 and 5, which return 0xffffffff.
- Prescale 3, count, snapshot:
  - Stimulus: write PRESCALE=3 and CTRL=1, wait 40 clks, then read COUNT_LO.
  - Required response: COUNT_LO returns 10.
  - Stimulus: read COUNT_HI.
  - Required response: COUNT_HI returns 0.
- One-shot match with irq:
  - Stimulus: write COMPARE_LO=5, COMPARE_HI=0, CTRL=3 (en, ie), PRESCALE=0.
  - Required response: irq rises on the edge where count becomes 5; count continues to 6, 7, ...; pending stays 1.
  - Stimulus: write STATUS=1.
  - Required response: irq drops the next cycle.
- Auto-reload:
  - Stimulus: CTRL=7, COMPARE=4, PRESCALE=0.
  - Required response: count sequence is 1, 2, 3, 0, 1, 2, 3, 0; pending sets on each wrap to 0.
- 64-bit wrap and snapshot coherence:
  - Stimulus: write COUNT_HI=0xffffffff, COUNT_LO=0xfffffffe, CTRL=1.
  - Required response: after 2 ticks, count=0.
  - Stimulus: read COUNT_LO when count=0x1_00000000.
  - Required response: COUNT_LO returns 0 and the following COUNT_HI read returns 1, even if a carry occurs between the two reads.
- Collisions:
  - Stimulus: W1C STATUS in the same cycle as a match.
  - Required response: pending stays 1.
  - Stimulus: write COUNT_LO=100 in a tick cycle.
  - Required response: count=100 on the next cycle, not 101.
